// File: rtl/pellet_eater.sv
// -----------------------------------------------------------------------------
// pellet_eater
//
// Per-frame pellet consumption controller. It sits in front of the second
// read/write port pair of the shared 80x60 background tile RAM (9-bit tile
// codes, one-cycle registered read).
//
// On each frame tick it reads the tile under Pac-Man. If that tile is a normal
// or power pellet, it writes EMPTY_CODE back. In the same cycle as the write
// it updates the score, the remaining-pellet count and the level-clear flag.
// A power pellet also raises a one-cycle power pulse.
//
// Ports
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   frame_tick    one-cycle pulse, once per frame
//   pac_tile_x    Pac-Man tile column (0..MAP_W-1 valid)
//   pac_tile_y    Pac-Man tile row    (0..MAP_H-1 valid)
//   rd_addr       RAM read address  (r_addra2)
//   rd_data       RAM read data     (douta2), valid one cycle after rd_addr
//   wr_addr       RAM write address (w_addra2)
//   wr_en         RAM write enable  (wea2), exactly one cycle per eaten tile
//   wr_data       RAM write data    (dina2)
//   score         accumulated score, saturating at 16'hFFFF
//   pellets_left  edible tiles remaining
//   power_pulse   one-cycle pulse, coincident with wr_en, for a power pellet
//   level_clear   sticky, set when pellets_left reaches 0
//   busy          high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module pellet_eater #(
  parameter int       MAP_W        = 80,
  parameter int       MAP_H        = 60,
  parameter logic [8:0] PELLET_CODE = 9'h001,
  parameter logic [8:0] POWER_CODE  = 9'h002,
  parameter logic [8:0] EMPTY_CODE  = 9'h000,
  parameter int       PELLET_PTS   = 10,
  parameter int       POWER_PTS    = 50,
  parameter int       PELLET_TOTAL = 244
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [6:0]  pac_tile_x,
  input  logic [5:0]  pac_tile_y,
  output logic [12:0] rd_addr,
  input  logic [8:0]  rd_data,
  output logic [12:0] wr_addr,
  output logic        wr_en,
  output logic [8:0]  wr_data,
  output logic [15:0] score,
  output logic [8:0]  pellets_left,
  output logic        power_pulse,
  output logic        level_clear,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    WRITE
  } state_t;

  localparam logic [6:0]  MAP_W_X    = 7'(MAP_W);
  localparam logic [5:0]  MAP_H_Y    = 6'(MAP_H);
  localparam logic [16:0] PELLET_INC = 17'(PELLET_PTS);
  localparam logic [16:0] POWER_INC  = 17'(POWER_PTS);

  state_t      state;
  logic [12:0] addr_q;      // tile address of the access in flight
  logic        is_power_q;  // code seen in CHECK, used for scoring in WRITE

  logic [12:0] y_ext;
  logic [12:0] tick_addr;
  logic        in_range;
  logic        is_edible;
  logic [16:0] score_sum;

  // y*80 + x as two shifts and adds; valid for the 80-column map.
  // NOTE: combinational logic goes in always_comb and every output gets a
  // value on every path, so no latch can be inferred.
  always_comb begin
    y_ext     = {7'd0, pac_tile_y};
    tick_addr = (y_ext << 6) + (y_ext << 4) + {6'd0, pac_tile_x};
    in_range  = (pac_tile_x < MAP_W_X) && (pac_tile_y < MAP_H_Y);
    is_edible = (rd_data == PELLET_CODE) || (rd_data == POWER_CODE);
    // One extra bit catches the carry so the score can saturate.
    score_sum = {1'b0, score} + (is_power_q ? POWER_INC : PELLET_INC);
  end

  assign busy = (state != IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      is_power_q   <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_en        <= 1'b0;
      wr_data      <= EMPTY_CODE;
      score        <= '0;
      pellets_left <= 9'(PELLET_TOTAL);
      power_pulse  <= 1'b0;
      level_clear  <= 1'b0;
    end else begin
      // Pulses default low; only the CHECK->WRITE transition raises them.
      wr_en       <= 1'b0;
      power_pulse <= 1'b0;

      case (state)
        IDLE: begin
          // Ticks while busy never reach here; ticks after level clear and
          // off-map coordinates are dropped without touching the RAM.
          if (frame_tick && !level_clear && in_range) begin
            rd_addr <= tick_addr;
            addr_q  <= tick_addr;
            state   <= READ;
          end
        end

        READ: state <= CHECK;  // RAM registers its output this cycle

        CHECK: begin
          if (is_edible) begin
            wr_addr     <= addr_q;
            wr_data     <= EMPTY_CODE;
            wr_en       <= 1'b1;
            is_power_q  <= (rd_data == POWER_CODE);
            power_pulse <= (rd_data == POWER_CODE);
            state       <= WRITE;
          end else begin
            state <= IDLE;
          end
        end

        WRITE: begin
          score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (pellets_left != 9'd0) begin
            pellets_left <= pellets_left - 9'd1;
            if (pellets_left == 9'd1) level_clear <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pellet_eater.sv
// -----------------------------------------------------------------------------
// tb_pellet_eater
//
// Directed bench for pellet_eater. A behavioural tile RAM with a one-cycle
// registered read sits on the RAM port pair. Every expected write is pushed to
// a scoreboard queue when its tick is driven, and popped and compared when the
// DUT raises wr_en. Score and pellet counts come from a small reference model.
// -----------------------------------------------------------------------------
module tb_pellet_eater;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [6:0]  pac_tile_x;
  logic [5:0]  pac_tile_y;
  logic [12:0] rd_addr;
  logic [8:0]  rd_data;
  logic [12:0] wr_addr;
  logic        wr_en;
  logic [8:0]  wr_data;
  logic [15:0] score;
  logic [8:0]  pellets_left;
  logic        power_pulse;
  logic        level_clear;
  logic        busy;

  always #5 Clk = ~Clk;

  pellet_eater dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .pac_tile_x   (pac_tile_x),
    .pac_tile_y   (pac_tile_y),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .score        (score),
    .pellets_left (pellets_left),
    .power_pulse  (power_pulse),
    .level_clear  (level_clear),
    .busy         (busy)
  );

  // ---------------------------------------------------------------------------
  // Tile RAM model: fixed initial layout, plus a bitmap of eaten tiles.
  // ---------------------------------------------------------------------------
  function automatic logic [8:0] init_tile(input logic [12:0] a);
    if (a < 13'd244) return 9'h001;          // level-clear run: addr 0..243
    case (a)
      13'd410, 13'd2430, 13'd4050, 13'd4005: return 9'h001;
      13'd4799, 13'd3240:                    return 9'h002;
      13'd1620:                              return 9'h0A0;
      default:                               return 9'h000;
    endcase
  endfunction

  logic [4799:0] eaten = '0;

  always @(posedge Clk) begin
    rd_data <= eaten[rd_addr] ? 9'h000 : init_tile(rd_addr);
    if (wr_en === 1'b1 && wr_data == 9'h000) eaten[wr_addr] <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [12:0] addr;
    logic        power;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int n_cmp    = 0;
  int n_err    = 0;
  int n_writes = 0;
  int score_m  = 0;
  int left_m   = 244;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every wr_en cycle must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (wr_en === 1'b1) begin
      exp_wr_t e;
      n_writes++;
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_wr_addr",     32'(wr_addr),     32'(e.addr));
        check("sb_wr_data",     32'(wr_data),     32'd0);
        check("sb_power_pulse", 32'(power_pulse), 32'(e.power));
      end
    end else if (power_pulse === 1'b1) begin
      check("stray_power_pulse", 32'(power_pulse), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic pulse_tick(input logic [6:0] x, input logic [5:0] y);
    @(negedge Clk);
    pac_tile_x = x;
    pac_tile_y = y;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  // Drive one tick on an edible tile and follow it through to the update.
  task automatic eat(input logic [6:0] x, input logic [5:0] y, input logic power,
                     input string tag);
    int a;
    exp_wr_t e;
    a = int'(y) * 80 + int'(x);
    e.addr  = 13'(a);
    e.power = power;
    exp_q.push_back(e);
    pulse_tick(x, y);                                  // now in READ
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'(a));
    check({tag, "_busy"},    32'(busy),    32'd1);
    repeat (2) @(negedge Clk);                         // now in WRITE
    check({tag, "_wr_en"},   32'(wr_en),   32'd1);
    @(negedge Clk);                                    // back in IDLE
    score_m = score_m + (power ? 50 : 10);
    if (score_m > 65535) score_m = 65535;
    if (left_m > 0) left_m--;
    check({tag, "_score"},       32'(score),        32'(score_m));
    check({tag, "_pellets"},     32'(pellets_left), 32'(left_m));
    check({tag, "_level_clear"}, 32'(level_clear),  32'(left_m == 0));
    check({tag, "_wr_en_off"},   32'(wr_en),        32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w0;
    Reset      = 1'b1;
    frame_tick = 1'b0;
    pac_tile_x = '0;
    pac_tile_y = '0;

    // Reset state after two reset cycles.
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst_score",       32'(score),        32'd0);
    check("rst_pellets",     32'(pellets_left), 32'd244);
    check("rst_wr_en",       32'(wr_en),        32'd0);
    check("rst_level_clear", 32'(level_clear),  32'd0);
    check("rst_busy",        32'(busy),         32'd0);
    check("rst_wr_data",     32'(wr_data),      32'd0);
    check("rst_rd_addr",     32'(rd_addr),      32'd0);

    // Normal pellet at (10,5) -> addr 410, and power pellet at the last tile.
    eat(7'd10, 6'd5,  1'b0, "pellet");
    eat(7'd79, 6'd59, 1'b1, "power");

    // Non-edible tile code 0x0A0 at (20,20) -> addr 1620.
    pulse_tick(7'd20, 6'd20);
    check("noedible_rd_addr", 32'(rd_addr), 32'd1620);
    repeat (2) @(negedge Clk);
    check("noedible_wr_en", 32'(wr_en), 32'd0);
    @(negedge Clk);
    check("noedible_busy",  32'(busy),  32'd0);
    check("noedible_score", 32'(score), 32'(score_m));

    // Off-map coordinates: no RAM access, FSM stays idle.
    pulse_tick(7'd80, 6'd0);
    check("oor_x_busy",    32'(busy),    32'd0);
    check("oor_x_rd_addr", 32'(rd_addr), 32'd1620);
    pulse_tick(7'd0, 6'd60);
    check("oor_y_busy",    32'(busy),    32'd0);
    check("oor_y_rd_addr", 32'(rd_addr), 32'd1620);

    // Back-to-back ticks on a pellet at (30,30): the second one is ignored.
    w0 = n_writes;
    exp_q.push_back('{addr: 13'd2430, power: 1'b0});
    @(negedge Clk);
    pac_tile_x = 7'd30;
    pac_tile_y = 6'd30;
    frame_tick = 1'b1;
    @(negedge Clk);                                    // second tick, in READ
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge Clk);
    score_m += 10;
    left_m--;
    check("dbl_writes",  32'(n_writes - w0), 32'd1);
    check("dbl_score",   32'(score),         32'(score_m));
    check("dbl_pellets", 32'(pellets_left),  32'(left_m));
    check("dbl_busy",    32'(busy),          32'd0);

    // Score saturation: preset score near the top and eat a power pellet.
    @(negedge Clk);
    force dut.score = 16'd65530;
    @(negedge Clk);
    release dut.score;
    score_m = 65530;
    check("sat_preset", 32'(score), 32'd65530);
    eat(7'd40, 6'd40, 1'b1, "sat");

    // Reset while in CHECK on a pellet at (50,50): no write, back to idle.
    pulse_tick(7'd50, 6'd50);                          // now in READ
    @(negedge Clk);                                    // now in CHECK
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_wr_en",   32'(wr_en),        32'd0);
    check("midrst_busy",    32'(busy),         32'd0);
    check("midrst_score",   32'(score),        32'd0);
    check("midrst_pellets", 32'(pellets_left), 32'd244);
    Reset   = 1'b0;
    score_m = 0;
    left_m  = 244;
    @(negedge Clk);
    check("postrst_wr_en", 32'(wr_en), 32'd0);

    // Clear the level: 244 pellets at addresses 0..243.
    for (int i = 0; i < 244; i++) begin
      eat(7'(i % 80), 6'(i / 80), 1'b0, "clear");
    end
    check("clear_flag",    32'(level_clear),  32'd1);
    check("clear_pellets", 32'(pellets_left), 32'd0);

    // After level clear a tick on a pellet (5,50) does nothing.
    pulse_tick(7'd5, 6'd50);
    check("cleared_busy",    32'(busy),    32'd0);
    check("cleared_rd_addr", 32'(rd_addr), 32'd243);
    repeat (3) @(negedge Clk);
    check("cleared_wr_en", 32'(wr_en),        32'd0);
    check("cleared_score", 32'(score),        32'(score_m));
    check("cleared_flag",  32'(level_clear),  32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
